xillybus_mem_responder: RTL and testbench
=========================================

# xillybus_mem_responder

User-side responder for the core's seekable 32-bit `mem_8` stream pair. It holds a 2^ADDR_W × DATA_W register array and a shared address pointer. The pointer is loaded by the core's address-update strobe and advanced by every accepted write or read. Write data is accepted on the `user_w_mem_8` port, and a prefetched read word is presented on the `user_r_mem_8` port with empty/eof flags, so the core can stream reads at one word per cycle.

## Interface
- `ADDR_W`, 5, pointer/array address width (array depth = 2^ADDR_W)
- `DATA_W`, 32, word width
- `bus_clk`  in  1  sole clock, rising edge
- `trn_reset_n`  in  1  asynchronous, active-low reset
- `user_w_mem_8_wren`  in  1  write strobe from core
- `user_w_mem_8_data`  in  DATA_W  write word
- `user_w_mem_8_full`  out  1  write backpressure
- `user_w_mem_8_open`  in  1  write stream open (informational, no gating)
- `user_r_mem_8_rden`  in  1  read strobe from core
- `user_r_mem_8_data`  out  DATA_W  prefetched read word
- `user_r_mem_8_empty`  out  1  prefetch word not valid
- `user_r_mem_8_eof`  out  1  end of array reached (see Configuration)
- `user_r_mem_8_open`  in  1  read stream open
- `user_mem_8_addr`  in  ADDR_W  seek address
- `user_mem_8_addr_update`  in  1  load pointer from `user_mem_8_addr`
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- **Reset values.** Array cleared to 0, `ptr`=0, prefetch state INVALID, `data`=0, `empty`=1, `eof`=0, `full`=1, `proto_err`=0.
- **Prefetch FSM**, two states:
  - INVALID → VALID on the next edge, loading `data`←mem[ptr]. This happens unless `addr_update`, an accepted write, or `r_open`=0 occurs in the same cycle.
  - VALID → INVALID on `addr_update`, an accepted write, or `r_open` low.
  - VALID with accepted `rden`: stay VALID and load `data`←mem[ptr+1]. This gives back-to-back reads.
  - `empty` = not VALID, registered.
- **Accepted write.** `wren`=1, `full`=0, no `addr_update`. Effect: mem[ptr]←`data`, then `ptr`←`ptr`+1 mod 2^ADDR_W.
- **Accepted read.** `rden`=1, `empty`=0, no `addr_update`. Effect: `ptr`←`ptr`+1.
- **Write and read in the same cycle, both accepted.**
  - The write lands at `ptr`.
  - The read consumes the current `data`.
  - `ptr` advances by 1 only.
  - Prefetch goes INVALID.
- **Seek.** `addr_update` has priority: `ptr`←`user_mem_8_addr`. A concurrent `wren` or `rden` is discarded and sets `proto_err`.
- **Violations.** `rden` while `empty`=1, or `wren` while `full`=1, is ignored and sets `proto_err`. `proto_err` clears only on reset.
- **`full`.** Registered. It is 1 in the cycle following `addr_update` (seek settle) and after reset until the first clock edge; otherwise 0, except as defined under Configuration.
- **Reset mid-operation.** Returns immediately (asynchronously) to the reset values. No partial write is committed.

## Timing
- **Seek.** `addr_update` at cycle N gives `ptr`=A at N+1, `full`=1 at N+1, and `empty`=0 with `data`=mem[A] at N+2.
- **Write.** `wren` at N makes mem[ptr] visible internally at N+1. `empty`=1 at N+1, then `empty`=0 with `data`=mem[ptr+1] at N+2.
- **Read.** `rden` at N (VALID) gives `data`=mem[ptr+1] at N+1 with `empty` unchanged. Sustained throughput is 1 word/cycle.
- **Wrap-around** (macro off). `ptr`=2^ADDR_W−1 plus an increment gives `ptr`=0. The read stream continues at mem[0].
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- Macro **`XILLY_MEM_RESPONDER_EOF_EN`**.
- **Defined:**
  - An increment from `ptr`=2^ADDR_W−1 sets an `at_end` flag instead of wrapping.
  - While `at_end` is set: `eof`=1, `empty`=1, `full`=1.
  - Reads and writes at end are violations (`proto_err`).
  - `addr_update` clears `at_end`, and `eof` drops at N+1.
- **Undefined:** `eof` is tied to 0 and the pointer wraps modulo 2^ADDR_W.

## Test plan
- **Write then seek-read.** Seek 0, write 0x11,0x22,0x33, seek 0, read 3 back-to-back → `data` sequence 0x11,0x22,0x33 on consecutive cycles; `empty`=0 throughout; `proto_err`=0.
- **Seek latency.** Preload mem[7]=0xDEADBEEF, `addr_update` with addr=7 at N → `full`=1 at N+1, `empty`=0 and `data`=0xDEADBEEF at N+2.
- **Wrap** (macro off). Seek 31, write 0xA, write 0xB → mem[31]=0xA, mem[0]=0xB, `ptr`=1; `eof` stays 0.
- **EOF** (macro on). Seek 30, read 2 words → after the second read `eof`=1, `empty`=1, `full`=1; a further `rden` sets `proto_err`; `addr_update` to 0 → `eof`=0 next cycle.
- **Collision and violation.** `addr_update` and `wren` in the same cycle → no array change, `ptr`=new addr, `proto_err`=1. Separately, `rden` while `empty`=1 → `ptr` unchanged, `proto_err`=1.
- **Async reset mid-stream.** Assert `trn_reset_n`=0 between clock edges during a read burst → immediately `empty`=1, `full`=1, `data`=0, `proto_err`=0, and array contents 0.

Source files
------------

// File: rtl/xillybus_mem_responder.sv
// ---------------------------------------------------------------------------
// xillybus_mem_responder
//
// User-side responder for a seekable Xillybus mem_8 stream pair. It holds a
// 2^ADDR_W x DATA_W register array and one shared address pointer.
// - Writes land at the pointer.
// - Reads are served from a one-word prefetch register, which allows
//   back-to-back reads at one word per cycle.
// - Every accepted write or read advances the pointer.
// - The core's addr_update strobe reloads the pointer.
//
// Optional feature (macro XILLY_MEM_RESPONDER_EOF_EN):
//   Incrementing past the last entry raises eof and blocks both streams,
//   instead of wrapping the pointer. Without the macro, eof is tied to 0
//   and the pointer wraps modulo 2^ADDR_W.
//
// Ports:
//   bus_clk, trn_reset_n     clock (rising edge) and async active-low reset
//   user_w_mem_8_*           write stream: wren/data in, full out, open in
//   user_r_mem_8_*           read stream: rden/open in, data/empty/eof out
//   user_mem_8_addr[_update] seek address and load strobe
//   proto_err                sticky protocol-violation flag
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module xillybus_mem_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic              user_w_mem_8_wren,
    input  logic [DATA_W-1:0] user_w_mem_8_data,
    output logic              user_w_mem_8_full,
    input  logic              user_w_mem_8_open,
    input  logic              user_r_mem_8_rden,
    output logic [DATA_W-1:0] user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    output logic              proto_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    typedef enum logic {PF_INVALID, PF_VALID} pf_state_t;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [ADDR_W-1:0]            ptr, ptr_next, ptr_inc;
    pf_state_t                    state, state_next;
    logic [DATA_W-1:0]            rd_data, data_next;
    logic                         full_q, perr_q, at_end, at_end_next;
    logic                         seek, wr_acc, rd_acc, viol, step, hit_end;
    logic                         invalidate;

    // Write-stream open is informational only; it does not gate anything.
    logic unused_w_open;
    assign unused_w_open = user_w_mem_8_open;

    // Transaction qualification. A seek wins over everything in its cycle.
    always_comb begin
        seek    = user_mem_8_addr_update;
        wr_acc  = user_w_mem_8_wren & ~full_q & ~seek;
        rd_acc  = user_r_mem_8_rden & (state == PF_VALID) & ~seek;
        viol    = (seek & (user_w_mem_8_wren | user_r_mem_8_rden))
                | (user_w_mem_8_wren & full_q)
                | (user_r_mem_8_rden & (state != PF_VALID));
        // A simultaneous write and read still advance the pointer once.
        step    = wr_acc | rd_acc;
        ptr_inc = ptr + ADDR_W'(1);
`ifdef XILLY_MEM_RESPONDER_EOF_EN
        hit_end = step & (ptr == PTR_MAX);
`else
        hit_end = 1'b0;
`endif
    end

    // Pointer and end-of-array tracking. At the end, the pointer parks on
    // the last entry, and at_end keeps both streams blocked until a seek.
    always_comb begin
        ptr_next    = ptr;
        at_end_next = at_end;
        if (seek) begin
            ptr_next    = user_mem_8_addr;
            at_end_next = 1'b0;
        end else if (step) begin
            if (hit_end) at_end_next = 1'b1;
            else         ptr_next    = ptr_inc;
        end
    end

    // Prefetch FSM. The VALID state always holds mem[ptr]. Any event that
    // would make that stale (seek, write, reader closed, end reached) drops
    // it to INVALID. INVALID refills on the next quiet cycle.
    always_comb begin
        state_next = state;
        data_next  = rd_data;
        invalidate = seek | wr_acc | ~user_r_mem_8_open | at_end_next;
        case (state)
            PF_INVALID: begin
                if (!invalidate) begin
                    state_next = PF_VALID;
                    data_next  = mem[ptr];
                end
            end
            PF_VALID: begin
                if (invalidate) begin
                    state_next = PF_INVALID;
                end else if (rd_acc) begin
                    data_next  = mem[ptr_inc];
                end
            end
            default: state_next = PF_INVALID;
        endcase
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state   <= PF_INVALID;
            rd_data <= '0;
        end else begin
            state   <= state_next;
            rd_data <= data_next;
        end
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            mem    <= '0;
            ptr    <= '0;
            at_end <= 1'b0;
            full_q <= 1'b1;
            perr_q <= 1'b0;
        end else begin
            if (wr_acc) mem[ptr] <= user_w_mem_8_data;
            ptr    <= ptr_next;
            at_end <= at_end_next;
            // One settle cycle after a seek, and blocked while at the end.
            full_q <= seek | at_end_next;
            perr_q <= perr_q | viol;
        end
    end

    assign user_w_mem_8_full  = full_q;
    assign user_r_mem_8_data  = rd_data;
    assign user_r_mem_8_empty = (state != PF_VALID);
    assign user_r_mem_8_eof   = at_end;
    assign proto_err          = perr_q;

endmodule

// File: tb/tb_xillybus_mem_responder.sv
module tb_xillybus_mem_responder;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wren = 1'b0, rden = 1'b0, au = 1'b0;
    logic          w_open = 1'b1, r_open = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] addr = '0;
    logic          full, empty, eof, perr;
    logic [DW-1:0] rdata;

    int tests = 0;
    int fails = 0;

    xillybus_mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .bus_clk(clk), .trn_reset_n(rst_n),
        .user_w_mem_8_wren(wren), .user_w_mem_8_data(wdata),
        .user_w_mem_8_full(full), .user_w_mem_8_open(w_open),
        .user_r_mem_8_rden(rden), .user_r_mem_8_data(rdata),
        .user_r_mem_8_empty(empty), .user_r_mem_8_eof(eof),
        .user_r_mem_8_open(r_open), .user_mem_8_addr(addr),
        .user_mem_8_addr_update(au), .proto_err(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge, then sample at the next negedge.
    task automatic cyc(input logic w, input logic [DW-1:0] wd, input logic r,
                       input logic u, input logic [AW-1:0] a);
        wren = w; wdata = wd; rden = r; au = u; addr = a;
        @(posedge clk);
        @(negedge clk);
        wren = 0; rden = 0; au = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; wren = 0; rden = 0; au = 0; r_open = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic          w;
        logic [DW-1:0] wd;
        logic          r;
        logic          u;
        logic [AW-1:0] a;
        logic          e_empty;
        logic          e_full;
        logic          chk_data;
        logic [DW-1:0] e_data;
        logic          e_perr;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic w, input logic [DW-1:0] wd, input logic r,
                                input logic u, input logic [AW-1:0] a, input logic ee,
                                input logic ef, input logic cd, input logic [DW-1:0] ed,
                                input logic ep);
        vec_t v;
        v.w = w; v.wd = wd; v.r = r; v.u = u; v.a = a;
        v.e_empty = ee; v.e_full = ef; v.chk_data = cd; v.e_data = ed; v.e_perr = ep;
        vecs.push_back(v);
    endfunction

    // Behavioural reference: an array, a pointer, and the rule that a
    // non-empty port always shows the word at the pointer.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr;
    bit            m_valid, m_full, m_perr, m_end;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ptr = 0; m_valid = 0; m_full = 1; m_perr = 0; m_end = 0;
    endtask

    task automatic model_step(input bit w, input logic [DW-1:0] wd, input bit r,
                              input bit u, input int a, input bit ro);
        bit wa, ra;
        wa = w && !m_full && !u;
        ra = r && m_valid && !u;
        if ((u && (w || r)) || (w && m_full) || (r && !m_valid)) m_perr = 1;
        if (wa) m_mem[m_ptr] = wd;
        if (u) begin
            m_ptr = a; m_end = 0;
        end else if (wa || ra) begin
`ifdef XILLY_MEM_RESPONDER_EOF_EN
            if (m_ptr == DEPTH - 1) m_end = 1;
            else m_ptr = m_ptr + 1;
`else
            m_ptr = (m_ptr + 1) % DEPTH;
`endif
        end
        m_valid = !(u || wa || !ro || m_end);
        m_full  = u || m_end;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 1);
        chk("reset_data", rdata, 0);
        chk("reset_eof", eof, 0);
        chk("reset_perr", perr, 0);

        // ---------------- directed table ----------------
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);             // first refill
        add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);             // seek 0
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);             // settle
        add(1, 32'h11, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 32'h22, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 32'h33, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);             // seek 0
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 32'h22, 0);        // back-to-back reads
        add(0, 0, 1, 0, 0, 0, 0, 1, 32'h33, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        add(0, 0, 0, 1, 7, 1, 1, 0, 0, 0);             // seek 7, preload
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        add(1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 7, 1, 1, 0, 0, 0);             // seek latency N
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);  // N+2
`ifndef XILLY_MEM_RESPONDER_EOF_EN
        add(0, 0, 0, 1, 31, 1, 1, 0, 0, 0);            // wrap
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        add(1, 32'hA, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 32'hB, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h22, 0);        // ptr now 1
        add(0, 0, 0, 1, 31, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 32'hB, 0);         // stream continues at mem[0]
`endif
        add(0, 0, 0, 1, 6, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 1);         // rden while empty
        add(1, 32'h99, 0, 1, 3, 1, 1, 0, 0, 1);        // seek + write collision
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1);         // mem[3] untouched

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].u, vecs[i].a);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d_eof", i), eof, 0);
            chk($sformatf("vec%0d_perr", i), perr, vecs[i].e_perr);
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), rdata, vecs[i].e_data);
        end

        // ---------------- async reset mid read burst ----------------
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        rden = 1;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("areset_empty", empty, 1);
        chk("areset_full", full, 1);
        chk("areset_data", rdata, 0);
        chk("areset_perr", perr, 0);
        rden = 0;
        @(negedge clk);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        chk("areset_mem0_empty", empty, 0);
        chk("areset_mem0", rdata, 0);
        cyc(0, 0, 0, 1, 7);
        cyc(0, 0, 0, 0, 0);
        chk("areset_mem7", rdata, 0);

`ifdef XILLY_MEM_RESPONDER_EOF_EN
        // ---------------- end-of-array ----------------
        do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 30);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("eof_pre", eof, 0);
        cyc(0, 0, 1, 0, 0);
        chk("eof_set", eof, 1);
        chk("eof_empty", empty, 1);
        chk("eof_full", full, 1);
        chk("eof_perr0", perr, 0);
        cyc(0, 0, 1, 0, 0);
        chk("eof_rd_perr", perr, 1);
        cyc(0, 0, 0, 1, 0);
        chk("eof_clear", eof, 0);
`endif

        // ---------------- randomized vs reference model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit            w, r, u, ro;
            logic [DW-1:0] wd;
            int            a;
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 0);
            u  = ($urandom_range(0, 9) == 0);
            ro = ($urandom_range(0, 15) != 0);
            wd = $urandom;
            a  = $urandom_range(0, DEPTH - 1);
            r_open = ro;
            model_step(w, wd, r, u, a, ro);
            cyc(w, wd, r, u, AW'(a));
            chk("rnd_empty", empty, !m_valid);
            chk("rnd_full", full, m_full);
            chk("rnd_eof", eof, m_end);
            chk("rnd_perr", perr, m_perr);
            if (m_valid) chk("rnd_data", rdata, m_mem[m_ptr]);
            if (fails > 20) break;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
